// File: rtl/nor_unit_arbiter_pkg.sv
// rtl/nor_unit_arbiter_pkg.sv - shared FSM encoding and requester indices for nor_unit_arbiter
package nor_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

endpackage

// File: rtl/bitwise_nor.sv
// rtl/bitwise_nor.sv - combinational bitwise NOR of two operands
module bitwise_nor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic [WIDTH-1:0] o_result
);

  assign o_result = ~(i_op1 | i_op2);

endmodule

// File: rtl/nor_unit_arbiter.sv
// rtl/nor_unit_arbiter.sv - round-robin sharing of one bitwise_nor between two requesters
// Optional grant counters enabled by NOR_ARB_GRANT_STATS_EN.
module nor_unit_arbiter
  import nor_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [WIDTH-1:0] i_op1_0,
  input  logic [WIDTH-1:0] i_op2_0,
  input  logic [WIDTH-1:0] i_op1_1,
  input  logic [WIDTH-1:0] i_op2_1,
  output logic [1:0]       o_rsp_valid,
  input  logic [1:0]       i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_grant_cnt0,
  output logic [CNT_W-1:0] o_grant_cnt1
);

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             owner;
  logic             winner;
  logic             req_hs;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [WIDTH-1:0] nor_y;
  logic [WIDTH-1:0] rsp_data_q;

  bitwise_nor #(
    .WIDTH (WIDTH)
  ) u_nor (
    .i_op1    (op1_q),
    .i_op2    (op2_q),
    .o_result (nor_y)
  );

  // Under contention the requester that did not win last time goes first.
  assign winner = (i_req_valid == 2'b11) ? ~last_grant : i_req_valid[REQ1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    o_req_ready = 2'b00;
    o_rsp_valid = 2'b00;
    req_hs      = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req_valid) begin
          o_req_ready[winner] = 1'b1;
          req_hs              = 1'b1;
          state_nxt           = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        o_rsp_valid[owner] = 1'b1;
        if (i_rsp_ready[owner]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      if (req_hs) begin
        owner      <= winner;
        last_grant <= winner;
        op1_q      <= winner ? i_op1_1 : i_op1_0;
        op2_q      <= winner ? i_op2_1 : i_op2_0;
      end
      // Result is kept after the response so late readers still see it.
      if (state == EXEC) begin
        rsp_data_q <= nor_y;
      end
    end
  end

  assign o_rsp_data = rsp_data_q;
  assign o_busy     = (state != IDLE);

`ifdef NOR_ARB_GRANT_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (req_hs) begin
      if (winner == 1'(REQ0) && cnt0_q != '1) begin
        cnt0_q <= cnt0_q + 1'b1;
      end
      if (winner == 1'(REQ1) && cnt1_q != '1) begin
        cnt1_q <= cnt1_q + 1'b1;
      end
    end
  end

  assign o_grant_cnt0 = cnt0_q;
  assign o_grant_cnt1 = cnt1_q;
`else
  assign o_grant_cnt0 = '0;
  assign o_grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_nor_unit_arbiter.sv
// tb/tb_nor_unit_arbiter.sv - randomized self-checking bench for nor_unit_arbiter
module tb_nor_unit_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] op1_0, op2_0, op1_1, op2_1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;
  logic [7:0] grant_cnt0, grant_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 = idle, 1 = computing, 2 = responding.
  int         m_phase;
  int         m_owner;
  int         m_last;
  logic [3:0] m_res;
  logic [3:0] m_data;
  int         m_cnt[2];
  logic [1:0] hs;
  int         dut_log[$];
  logic [3:0] rsp_log[$];

  nor_unit_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_op1_0      (op1_0),
    .i_op2_0      (op2_0),
    .i_op1_1      (op1_1),
    .i_op2_1      (op2_1),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy),
    .o_grant_cnt0 (grant_cnt0),
    .o_grant_cnt1 (grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0;
    m_owner = 0;
    m_last  = 1;
    m_data  = 4'h0;
    m_res   = 4'h0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    dut_log.delete();
    rsp_log.delete();
  endtask

  task automatic set_ops(input int k, input logic [3:0] a, input logic [3:0] b);
    if (k == 0) begin op1_0 = a; op2_0 = b; end
    else        begin op1_1 = a; op2_1 = b; end
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt0", grant_cnt0, 0);
    chk("rst_cnt1", grant_cnt1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  // One clock: compare outputs with the model at the negedge, then advance the model.
  task automatic step();
    logic [1:0] er, ev;
    int w;
    @(negedge clk);
    er = 2'b00;
    ev = 2'b00;
    hs = 2'b00;
    w  = 0;
    if (m_phase == 0 && req_valid != 2'b00) begin
      w = (req_valid == 2'b11) ? 1 - m_last : (req_valid[1] ? 1 : 0);
      er[w] = 1'b1;
    end
    if (m_phase == 2) ev[m_owner] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_data", rsp_data, m_data);
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
`ifdef NOR_ARB_GRANT_STATS_EN
    chk("cnt0", grant_cnt0, m_cnt[0]);
    chk("cnt1", grant_cnt1, m_cnt[1]);
`else
    chk("cnt0", grant_cnt0, 0);
    chk("cnt1", grant_cnt1, 0);
`endif
    for (int k = 0; k < 2; k++) begin
      if (req_ready[k] && req_valid[k]) dut_log.push_back(k);
      if (rsp_valid[k] && rsp_ready[k]) rsp_log.push_back(rsp_data);
    end
    case (m_phase)
      0: if (req_valid != 2'b00) begin
        hs[w]   = 1'b1;
        m_owner = w;
        m_last  = w;
        m_res   = (w == 1) ? ~(op1_1 | op2_1) : ~(op1_0 | op2_0);
        if (m_cnt[w] < 255) m_cnt[w]++;
        m_phase = 1;
      end
      1: begin
        m_data  = m_res;
        m_phase = 2;
      end
      default: if (rsp_ready[m_owner]) m_phase = 0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic drain();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int c = 0; c < 10 && m_phase != 0; c++) step();
    chk("drain_idle", m_phase, 0);
  endtask

  initial begin
    logic [3:0] exp_v;
    int n_before;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    op1_0 = 4'h0; op2_0 = 4'h0; op1_1 = 4'h0; op2_1 = 4'h0;
    do_reset();

    // Single request from requester 0.
    set_ops(0, 4'b0101, 4'b0011);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    step();
    req_valid = 2'b00;
    step();
    chk("single_valid", rsp_valid, 2'b01);
    chk("single_data", rsp_data, 4'b1000);
    step();
    chk("single_done_valid", rsp_valid, 2'b00);
    chk("single_hold_data", rsp_data, 4'b1000);

    // Contention straight out of reset, held for four transactions.
    do_reset();
    set_ops(0, 4'b1010, 4'b0100);
    set_ops(1, 4'b1111, 4'b0000);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int c = 0; c < 40 && dut_log.size() < 4; c++) step();
    drain();
    chk("cont_grants", dut_log.size(), 4);
    if (dut_log.size() >= 4) begin
      chk("fair_g0", dut_log[0], 0);
      chk("fair_g1", dut_log[1], 1);
      chk("fair_g2", dut_log[2], 0);
      chk("fair_g3", dut_log[3], 1);
    end
    chk("cont_rsps", (rsp_log.size() >= 2) ? 1 : 0, 1);
    if (rsp_log.size() >= 2) begin
      chk("cont_data0", rsp_log[0], 4'b0001);
      chk("cont_data1", rsp_log[1], 4'b0000);
    end

    // Back-pressure on requester 0 with requester 1 pending.
    set_ops(0, 4'($urandom), 4'($urandom));
    exp_v = ~(op1_0 | op2_0);
    req_valid = 2'b01;
    rsp_ready = 2'b10;
    step();
    req_valid = 2'b10;
    set_ops(1, 4'($urandom), 4'($urandom));
    step();
    n_before = dut_log.size();
    for (int c = 0; c < 5; c++) step();
    chk("bp_valid", rsp_valid, 2'b01);
    chk("bp_ready", req_ready, 2'b00);
    chk("bp_data", rsp_data, exp_v);
    chk("bp_no_grant", dut_log.size(), n_before);
    rsp_ready = 2'b01;
    step();
    step();
    chk("bp_next_grant", dut_log[dut_log.size()-1], 1);
    drain();

    // Reset while the operation is in EXEC.
    set_ops(0, 4'($urandom), 4'($urandom));
    req_valid = 2'b01;
    step();
    chk("rst_exec_busy", busy, 1);
    do_reset();
    rsp_ready = 2'b11;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("post_rst_valid", rsp_valid, 2'b00);
    end

    // Randomized traffic, requesters hold valid until accepted.
    for (int c = 0; c < 400; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (hs[k] || !req_valid[k]) begin
          req_valid[k] = ($urandom_range(0, 3) != 0);
          set_ops(k, 4'($urandom), 4'($urandom));
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
    end
    drain();

    // Every operand pair through requester 1.
    do_reset();
    rsp_ready = 2'b11;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        set_ops(1, a[3:0], b[3:0]);
        exp_v = ~(a[3:0] | b[3:0]);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        chk("exh_data", rsp_data, exp_v);
        step();
      end
    end
`ifdef NOR_ARB_GRANT_STATS_EN
    chk("exh_cnt1", grant_cnt1, 255);
    chk("exh_cnt0", grant_cnt0, 0);
`else
    chk("exh_cnt1", grant_cnt1, 0);
    chk("exh_cnt0", grant_cnt0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
